data_ram_arbiter: RTL and testbench

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

---
 rtl/data_ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_data_ram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Purpose: two-master arbiter for the single-port data RAM (m0 = CPU data port, m1 = loader/DMA).
// Latency: first ack one cycle after req rises; back-to-back accesses at one per cycle while owned.
// Backpressure: a master holds req and request signals until ack; loser waits, owner yields after MAX_HOLD acks.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   mN_req/we/sel/addr/wdata  master N request (N = 0, 1)
//   mN_rdata, mN_ack      master N read data (zero unless acked read) and access-done strobe
//   ram_ce/we/sel/addr/data_o  to data_ram; ram_data_i combinational read data from data_ram
//   owner                 00 IDLE, 01 OWN0, 10 OWN1
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-break in IDLE
// (default: fixed priority, m0 wins a tie).
module data_ram_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [3:0]  m0_sel,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [3:0]  m1_sel,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [3:0]  ram_sel,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   // Counter value on the last ack an owner may take while the other master waits.
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, hold_cnt_nxt;

`ifdef ARB_ROUND_ROBIN_EN
   // 0: m0 was the most recent new owner, 1: m1 was.
   logic       last_owner, last_owner_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner <= last_owner_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      case (state)
         IDLE: begin
            hold_cnt_nxt = 8'd0;
            if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               state_nxt = last_owner ? OWN0 : OWN1;
`else
               state_nxt = OWN0;
`endif
            end else if (m0_req) begin
               state_nxt = OWN0;
            end else if (m1_req) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (m0_req) begin
               if (hold_cnt == HOLD_LAST) begin
                  // Hold budget spent: yield if m1 waits, else saturate and keep going.
                  if (m1_req) begin
                     state_nxt    = OWN1;
                     hold_cnt_nxt = 8'd0;
                  end
               end else begin
                  hold_cnt_nxt = hold_cnt + 8'd1;
               end
            end else begin
               state_nxt    = m1_req ? OWN1 : IDLE;
               hold_cnt_nxt = 8'd0;
            end
         end
         OWN1: begin
            if (m1_req) begin
               if (hold_cnt == HOLD_LAST) begin
                  if (m0_req) begin
                     state_nxt    = OWN0;
                     hold_cnt_nxt = 8'd0;
                  end
               end else begin
                  hold_cnt_nxt = hold_cnt + 8'd1;
               end
            end else begin
               state_nxt    = m0_req ? OWN0 : IDLE;
               hold_cnt_nxt = 8'd0;
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = 8'd0;
         end
      endcase
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      last_owner_nxt = last_owner;
      if (state_nxt == OWN0 && state != OWN0) last_owner_nxt = 1'b0;
      if (state_nxt == OWN1 && state != OWN1) last_owner_nxt = 1'b1;
   end
`endif

   // Acks come straight from the registered owner and the live req, so a
   // handover to a master that is already requesting costs no dead cycle.
   always_comb begin
      m0_ack     = (state == OWN0) && m0_req;
      m1_ack     = (state == OWN1) && m1_req;
      ram_ce     = m0_ack | m1_ack;
      ram_we     = (m0_ack & m0_we) | (m1_ack & m1_we);
      ram_sel    = ({4{m0_ack}} & m0_sel) | ({4{m1_ack}} & m1_sel);
      ram_addr   = ({32{m0_ack}} & m0_addr) | ({32{m1_ack}} & m1_addr);
      ram_data_o = ({32{m0_ack}} & m0_wdata) | ({32{m1_ack}} & m1_wdata);
      m0_rdata   = (m0_ack && !m0_we) ? ram_data_i : 32'd0;
      m1_rdata   = (m1_ack && !m1_we) ? ram_data_i : 32'd0;
      owner      = state;
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;
   localparam int MAX_HOLD = 8;

   logic        clk, rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [3:0]  m0_sel, m1_sel;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic        m0_ack, m1_ack;
   logic        ram_ce, ram_we;
   logic [3:0]  ram_sel;
   logic [31:0] ram_addr, ram_data_o, ram_data_i;
   logic [1:0]  owner;

   data_ram_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
      .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .owner(owner)
   );

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        q0[$], q1[$];
   int          checks = 0, errors = 0;
   logic [31:0] mem    [64];
   logic [31:0] shadow [64];
   logic        mem_init;
   logic [1:0]  acked;
   logic [31:0] last_rdata0;
   bit          force_we;
   // Reference arbiter: current owner (0 none, 1 m0, 2 m1), length of the
   // current owner's ack run, and index of the last master that became owner.
   int          mcur, run, last;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'h5A000000 ^ {4{8'(i)}};
   endfunction

   // Data RAM model: combinational read, byte-lane write at the rising edge.
   assign ram_data_i = mem[ram_addr[7:2]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (ram_ce && ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_sel[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic access(input int n);
      txn_t        t;
      logic [31:0] rd, other_rd, exp_rd;
      if (n == 0) begin
         if (q0.size() == 0) begin chk("m0_unexpected_ack", 1, 0); return; end
         t = q0.pop_front(); rd = m0_rdata; other_rd = m1_rdata;
      end else begin
         if (q1.size() == 0) begin chk("m1_unexpected_ack", 1, 0); return; end
         t = q1.pop_front(); rd = m1_rdata; other_rd = m0_rdata;
      end
      chk($sformatf("m%0d_ram_we", n), ram_we, t.we);
      chk($sformatf("m%0d_ram_sel", n), ram_sel, t.sel);
      chk($sformatf("m%0d_ram_addr", n), ram_addr, t.addr);
      chk($sformatf("m%0d_ram_data_o", n), ram_data_o, t.wdata);
      exp_rd = t.we ? 32'd0 : shadow[t.addr[7:2]];
      chk($sformatf("m%0d_rdata", n), rd, exp_rd);
      chk($sformatf("m%0d_other_rdata", n), other_rd, 0);
      if (n == 0) last_rdata0 = rd;
      if (t.we)
         for (int b = 0; b < 4; b++)
            if (t.sel[b]) shadow[t.addr[7:2]][b*8 +: 8] = t.wdata[b*8 +: 8];
   endtask

   // Monitor: compares every cycle against the reference arbiter and pops the
   // scoreboard whenever the DUT acks a master.
   always @(negedge clk) begin : monitor
      int   nxt;
      logic r0, r1, e0, e1;
      if (rst) begin
         if (mem_init) for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
         chk("rst_outputs_zero", 32'(|{ram_ce, ram_we, ram_sel, ram_addr, ram_data_o,
                                      m0_ack, m1_ack, m0_rdata, m1_rdata}), 0);
         chk("rst_owner", 32'(owner), 0);
         q0.delete(); q1.delete();
         acked = 2'b00; mcur = 0; run = 0; last = 0;
      end else begin
         r0 = m0_req; r1 = m1_req;
         e0 = (mcur == 1) && r0;
         e1 = (mcur == 2) && r1;
         chk("m0_ack", 32'(m0_ack), 32'(e0));
         chk("m1_ack", 32'(m1_ack), 32'(e1));
         chk("owner", 32'(owner), mcur);
         chk("ram_ce", 32'(ram_ce), 32'(e0 | e1));
         acked = {m1_ack, m0_ack};
         if (m0_ack) access(0);
         else if (m1_ack) access(1);
         else chk("ram_idle_zero", 32'(|{ram_we, ram_sel, ram_addr, ram_data_o,
                                         m0_rdata, m1_rdata}), 0);
         // Next owner from the arbitration rules.
         nxt = mcur;
         case (mcur)
            0: begin
               if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
                  nxt = (last == 0) ? 2 : 1;
`else
                  nxt = 1;
`endif
               end else if (r0) nxt = 1;
               else if (r1) nxt = 2;
               else nxt = 0;
            end
            1: if (r0) begin run++; nxt = (run >= MAX_HOLD && r1) ? 2 : 1; end
               else nxt = r1 ? 2 : 0;
            default: if (r1) begin run++; nxt = (run >= MAX_HOLD && r0) ? 1 : 2; end
               else nxt = r0 ? 1 : 0;
         endcase
         if (nxt != mcur) run = 0;
         if (nxt != 0 && nxt != mcur) last = nxt - 1;
         mcur = nxt;
      end
   end

   task automatic issue(input int n, input txn_t t);
      if (n == 0) begin
         m0_req = 1'b1; m0_we = t.we; m0_sel = t.sel; m0_addr = t.addr; m0_wdata = t.wdata;
         q0.push_back(t);
      end else begin
         m1_req = 1'b1; m1_we = t.we; m1_sel = t.sel; m1_addr = t.addr; m1_wdata = t.wdata;
         q1.push_back(t);
      end
   endtask

   task automatic drive_master(input int n, input bit want);
      txn_t t;
      bit   busy;
      busy = (n == 0) ? (m0_req && !acked[0]) : (m1_req && !acked[1]);
      if (busy) return;
      if (want) begin
         t.we    = force_we ? 1'b1 : 1'($urandom_range(0, 1));
         t.sel   = 4'($urandom_range(1, 15));
         t.addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         t.wdata = $urandom;
         issue(n, t);
      end else if (n == 0) m0_req = 1'b0;
      else m1_req = 1'b0;
   endtask

   task automatic drive_cycle(input bit w0, input bit w1);
      drive_master(0, w0);
      drive_master(1, w1);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (!m0_req && !m1_req) break;
         drive_cycle(1'b0, 1'b0);
         step();
      end
      chk("drain_done", 32'({m0_req, m1_req}), 0);
   endtask

   task automatic do_txn(input int n, input txn_t t);
      issue(n, t);
      for (int i = 0; i < 20; i++) begin
         step();
         if (acked[n]) break;
      end
      chk($sformatf("m%0d_txn_ack_seen", n), 32'(acked[n]), 1);
      if (n == 0) m0_req = 1'b0; else m1_req = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      txn_t        t;
      int          first_m0, last_m0, first_m1, m0_cnt, p0, p1;
      logic [31:0] a, old;
      rst = 1'b1; mem_init = 1'b1; force_we = 1'b0;
      acked = 2'b00;
      m0_req = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; mem_init = 1'b0;

      // Single m0 read right after reset: no grant in the request cycle, data next cycle.
      t = '{we: 1'b0, sel: 4'hF, addr: 32'h10, wdata: 32'h0};
      issue(0, t);
      @(negedge clk);
      chk("first_cycle_ram_ce", 32'(ram_ce), 0);
      chk("first_cycle_m0_ack", 32'(m0_ack), 0);
      @(negedge clk);
      chk("lat1_m0_ack", 32'(m0_ack), 1);
      chk("lat1_m0_rdata", m0_rdata, 32'hDEADBEEF);
      step();
      m0_req = 1'b0;

      // m1 partial write, then m0 reads it back.
      do_txn(1, '{we: 1'b1, sel: 4'b0011, addr: 32'h20, wdata: 32'hA5A5A5A5});
      do_txn(0, '{we: 1'b0, sel: 4'hF, addr: 32'h20, wdata: 32'h0});
      chk("readback_low_half", 32'(last_rdata0[15:0]), 32'h0000A5A5);
      chk("readback_high_half", 32'(last_rdata0[31:16]), 32'(init_word(8) >> 16));

      // Simultaneous requests from IDLE; last owner was m0.
      step(); step();
      issue(0, '{we: 1'b0, sel: 4'hF, addr: 32'h30, wdata: 32'h0});
      issue(1, '{we: 1'b0, sel: 4'hF, addr: 32'h34, wdata: 32'h0});
      @(negedge clk);
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      chk("tie_winner_m1", 32'({m1_ack, m0_ack}), 32'b10);
`else
      chk("tie_winner_m0", 32'({m1_ack, m0_ack}), 32'b01);
`endif
      step();
      drain();
      step(); step();

      // Hold limit: m0 streams, m1 joins at cycle 2.
      first_m0 = -1; last_m0 = -1; first_m1 = -1; m0_cnt = 0;
      for (int c = 0; c < 14; c++) begin
         drive_cycle(1'b1, c >= 2);
         @(negedge clk);
         if (first_m1 < 0) begin
            if (m1_ack) first_m1 = c;
            if (m0_ack) begin
               if (first_m0 < 0) first_m0 = c;
               last_m0 = c;
               m0_cnt++;
            end
         end
         step();
      end
      chk("hold_m0_ack_count", m0_cnt, MAX_HOLD);
      chk("hold_m0_consecutive", last_m0 - first_m0 + 1, m0_cnt);
      chk("hold_first_m0_cycle", first_m0, 1);
      chk("handover_no_gap", first_m1, last_m0 + 1);
      drain();
      step(); step();

      // Asynchronous reset in the middle of an m1 write burst.
      force_we = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive_cycle(1'b0, 1'b1);
         step();
      end
      force_we = 1'b0;
      chk("burst_m1_acked", 32'(m1_ack), 1);
      a = m1_addr;
      old = mem[a[7:2]];
      m1_wdata = ~old;
      m1_sel = 4'hF;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ram_ce", 32'(ram_ce), 0);
      chk("async_rst_m1_ack", 32'(m1_ack), 0);
      chk("async_rst_ram_we", 32'(ram_we), 0);
      chk("async_rst_owner", 32'(owner), 0);
      m0_req = 1'b0; m1_req = 1'b0;
      step();
      chk("async_rst_no_write", mem[a[7:2]], old);
      step();
      rst = 1'b0;

      // Randomized traffic with varying request densities.
      p0 = 50; p1 = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) begin
            p0 = (c % 1000 == 0) ? 100 : 10 * $urandom_range(1, 10);
            p1 = 10 * $urandom_range(1, 10);
         end
         drive_cycle($urandom_range(0, 99) < p0, $urandom_range(0, 99) < p1);
         step();
      end
      drain();
      step(); step();
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
